vnub: RTL
=========

Name: vnub

Overview:
Variable (bit) node update block for the LDPC min/psi decoder. It is the return path of the check node update. It takes one channel LLR and up to MAX_ROWS check-to-bit messages, all in sign-magnitude form. For each edge it produces the extrinsic bit-to-check message, which is the channel LLR plus all incoming messages except that edge's own. It also produces the hard-decision bit. Accumulation is serial, one edge per cycle, under a one-hot FSM with a start/done handshake matching the check node block.

Parameters:
MAX_ROWS, 4, maximum variable-node degree (number of check-node edges)
WIDTH_LLR, 6, magnitude bit width of every LLR/message (sign carried separately)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
start  input  1  begin computation; sampled only in IDLE
deg  input  $clog2(MAX_ROWS+1)  active edge count; values > MAX_ROWS treated as MAX_ROWS
ch_llr_in  input  WIDTH_LLR  channel LLR magnitude
ch_sign_in  input  1  channel LLR sign (1 => negative)
llr_in  input  MAX_ROWS*WIDTH_LLR  incoming check messages, edge j at [j*WIDTH_LLR +: WIDTH_LLR]
sign_in  input  MAX_ROWS  incoming message signs, bit j = edge j
llr_out  output  MAX_ROWS*WIDTH_LLR  extrinsic message magnitudes, same packing
sign_out  output  MAX_ROWS  extrinsic message signs
hard_bit  output  1  hard decision (1 => total LLR negative)
done  output  1  high exactly one cycle when outputs are valid

Behaviour:
- Clocking and reset: single clock clk. Asynchronous active-low reset rst_n returns state to IDLE and clears every register, including llr_out, sign_out, hard_bit and all internal values. done is 0 during and after reset.
- Internal arithmetic:
  - Two's complement, accumulator width SUM_W = WIDTH_LLR+1+$clog2(MAX_ROWS+1).
  - Sign-magnitude to two's complement: value = sign ? -mag : +mag. Negative zero becomes 0.
- FSM (one-hot): IDLE, ACC, SUB, OUT, RETURN.
  - IDLE: on start=1, capture deg (clamped), ch_*, llr_in and sign_in into input registers. Load acc with the converted channel LLR, set idx=0, go to ACC. Otherwise stay in IDLE.
  - ACC: acc += converted msg[idx] if idx < deg, else += 0. idx increments every cycle. After the cycle with idx = MAX_ROWS-1, go to SUB. ACC always lasts exactly MAX_ROWS cycles, independent of deg.
  - SUB: register ext[j] = acc - msg[j] for j < deg, and ext[j] = 0 for j >= deg. Go to OUT.
  - OUT: register llr_out[j] = min(|ext[j]|, 2^WIDTH_LLR-1) and sign_out[j] = (ext[j] < 0). Register hard_bit = (acc < 0). Go to RETURN.
  - RETURN: done=1 (combinational decode of state). Go to IDLE unconditionally.
- Latency: done is high in the cycle after the (MAX_ROWS+2)th rising edge following the edge that sampled start (6 edges for MAX_ROWS=4). Throughput is one update per MAX_ROWS+4 cycles.
- Output hold: llr_out, sign_out and hard_bit change only in OUT. They hold their values from done until the next OUT or reset.
- Boundary cases:
  - start while not in IDLE (including RETURN) is ignored. Input changes after capture have no effect.
  - Zero total or zero extrinsic gives sign 0 (positive) and hard_bit 0.
  - deg=0: outputs all zero, hard_bit = channel sign (0 if the channel magnitude is 0).
  - Saturation is applied only at OUT. The accumulator never overflows at the given SUM_W.
  - Reset mid-operation aborts immediately. The next start runs normally.

Decomposition:
- Shared package ldpc_pkg:
  - WIDTH_LLR default
  - LLR_MAX = 2^WIDTH_LLR-1
  - function sum_width(width, n)
  - one-hot state constants for the check node and bit node FSMs
- One natural sub-module, llr_tc2sm: combinational two's complement to sign-magnitude with saturation. It is instantiated MAX_ROWS times in the OUT path.

Test Plan:
(MAX_ROWS=4, WIDTH_LLR=6; "+5/-3" means sign-magnitude inputs)
1. Basic: ch=+10, msgs +5,-3,+7,-2, deg=4 -> sign_out=0000, llr_out=12,20,10,19 (edge0..3), hard_bit=0, done exactly 6 edges after start and high for one cycle.
2. Saturation: ch=+60, msgs +30 x4 -> all llr_out=63, signs 0, hard_bit 0. Repeat with all negative inputs -> llr_out=63, sign_out=1111, hard_bit=1.
3. Partial degree: deg=2, ch=-4, msgs +9,+1,+50,+50 -> edge0 = -3 (sign 1, mag 3), edge1 = +5, edges 2 and 3 = 0 with sign 0, hard_bit=0.
4. Zero and negative-zero: ch sign=1 mag=0, all msgs 0, deg=4 -> all llr_out=0, sign_out=0000, hard_bit=0.
5. Protocol and reset:
   - start pulses during ACC and during RETURN are ignored: exactly one done per accepted start, outputs unchanged.
   - rst_n pulsed low mid-ACC -> outputs immediately 0, no done.
   - A following start completes with correct results.
6. Input stability: change llr_in every cycle after start is sampled -> results match the values present at the sampling edge.

Source files
------------

// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_pkg
// Description : Shared definitions for the LDPC min/psi decoder blocks:
//               default LLR width, saturation limit, accumulator width
//               helper and the one-hot state encodings of the check node
//               and bit node FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

  localparam int DEF_WIDTH_LLR = 6;
  localparam int LLR_MAX       = (1 << DEF_WIDTH_LLR) - 1;

  // Two's complement accumulator width for n magnitudes of 'width' bits plus
  // a channel value: one sign bit and enough headroom for n+1 terms.
  function automatic int sum_width(input int width, input int n);
    return width + 1 + $clog2(n + 1);
  endfunction

  // Check node FSM (one-hot)
  localparam int                 CN_ST_W   = 4;
  localparam logic [CN_ST_W-1:0] CN_IDLE   = 4'b0001;
  localparam logic [CN_ST_W-1:0] CN_SCAN   = 4'b0010;
  localparam logic [CN_ST_W-1:0] CN_OUT    = 4'b0100;
  localparam logic [CN_ST_W-1:0] CN_RETURN = 4'b1000;

  // Bit node FSM (one-hot)
  localparam int                 BN_ST_W   = 5;
  localparam logic [BN_ST_W-1:0] BN_IDLE   = 5'b00001;
  localparam logic [BN_ST_W-1:0] BN_ACC    = 5'b00010;
  localparam logic [BN_ST_W-1:0] BN_SUB    = 5'b00100;
  localparam logic [BN_ST_W-1:0] BN_OUT    = 5'b01000;
  localparam logic [BN_ST_W-1:0] BN_RETURN = 5'b10000;

endpackage
`default_nettype wire

// File: rtl/llr_tc2sm.sv
`default_nettype none
// ============================================================================
// Module      : llr_tc2sm
// Description : Combinational two's complement to sign-magnitude conversion
//               with magnitude saturation to 2^OUT_W-1. Zero maps to +0.
// Ports       : val  - signed input value (IN_W bits)
//               mag  - saturated magnitude (OUT_W bits)
//               sign - 1 when val is negative
// Revision    : 1.0 - initial release
// ============================================================================
module llr_tc2sm #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 6
) (
  input  logic signed [IN_W-1:0]  val,
  output logic        [OUT_W-1:0] mag,
  output logic                    sign
);

  localparam logic [IN_W-1:0] SAT = IN_W'((1 << OUT_W) - 1);

  logic [IN_W-1:0] abs_w;

  always_comb begin
    sign  = val[IN_W-1];
    // The accumulator never reaches the most negative value, so negation
    // cannot overflow here.
    abs_w = sign ? IN_W'(-val) : IN_W'(val);
    mag   = (abs_w > SAT) ? {OUT_W{1'b1}} : abs_w[OUT_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/vnub.sv
`default_nettype none
// ============================================================================
// Module      : vnub
// Description : Variable (bit) node update. Serially accumulates the channel
//               LLR and up to MAX_ROWS check-to-bit messages, then produces
//               each edge's extrinsic message (total minus own message) in
//               saturated sign-magnitude form plus the hard decision.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, deg          - request and active edge count (clamped)
//               ch_llr_in/ch_sign_in- channel LLR, sign-magnitude
//               llr_in/sign_in      - packed incoming messages, edge j at
//                                     [j*WIDTH_LLR +: WIDTH_LLR] / bit j
//               llr_out/sign_out    - packed extrinsic messages, same packing
//               hard_bit            - 1 when total LLR is negative
//               done                - one-cycle pulse, outputs valid
// Revision    : 1.0 - initial release
// ============================================================================
module vnub
  import ldpc_pkg::*;
#(
  parameter int MAX_ROWS  = 4,
  parameter int WIDTH_LLR = ldpc_pkg::DEF_WIDTH_LLR
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]   deg,
  input  logic [WIDTH_LLR-1:0]            ch_llr_in,
  input  logic                            ch_sign_in,
  input  logic [MAX_ROWS*WIDTH_LLR-1:0]   llr_in,
  input  logic [MAX_ROWS-1:0]             sign_in,
  output logic [MAX_ROWS*WIDTH_LLR-1:0]   llr_out,
  output logic [MAX_ROWS-1:0]             sign_out,
  output logic                            hard_bit,
  output logic                            done
);

  localparam int DEG_W = $clog2(MAX_ROWS + 1);
  localparam int IDX_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam int SUM_W = sum_width(WIDTH_LLR, MAX_ROWS);

  // Sign-magnitude to two's complement; a negative zero becomes 0.
  function automatic logic signed [SUM_W-1:0] to_tc(input logic s,
                                                    input logic [WIDTH_LLR-1:0] m);
    logic signed [SUM_W-1:0] v;
    v = $signed({{(SUM_W-WIDTH_LLR){1'b0}}, m});
    return s ? -v : v;
  endfunction

  logic [BN_ST_W-1:0]            state_q, state_d;
  logic [DEG_W-1:0]              deg_q, deg_d;
  logic [MAX_ROWS*WIDTH_LLR-1:0] mag_q, mag_d;
  logic [MAX_ROWS-1:0]           sgn_q, sgn_d;
  logic signed [SUM_W-1:0]       acc_q, acc_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [SUM_W-1:0]       ext_q [MAX_ROWS];
  logic signed [SUM_W-1:0]       ext_d [MAX_ROWS];
  logic [MAX_ROWS*WIDTH_LLR-1:0] llr_out_q, llr_out_d;
  logic [MAX_ROWS-1:0]           sign_out_q, sign_out_d;
  logic                          hard_bit_q, hard_bit_d;

  logic [DEG_W-1:0]              deg_clamped;
  logic [WIDTH_LLR-1:0]          sat_mag [MAX_ROWS];
  logic [MAX_ROWS-1:0]           sat_sgn;

  assign deg_clamped = (deg > DEG_W'(MAX_ROWS)) ? DEG_W'(MAX_ROWS) : deg;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BN_IDLE;
      deg_q      <= '0;
      mag_q      <= '0;
      sgn_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      llr_out_q  <= '0;
      sign_out_q <= '0;
      hard_bit_q <= 1'b0;
      for (int j = 0; j < MAX_ROWS; j++) ext_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      deg_q      <= deg_d;
      mag_q      <= mag_d;
      sgn_q      <= sgn_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      llr_out_q  <= llr_out_d;
      sign_out_q <= sign_out_d;
      hard_bit_q <= hard_bit_d;
      for (int j = 0; j < MAX_ROWS; j++) ext_q[j] <= ext_d[j];
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      BN_IDLE:   if (start) state_d = BN_ACC;
      // ACC runs a fixed MAX_ROWS cycles so latency does not depend on deg.
      BN_ACC:    if (idx_q == IDX_W'(MAX_ROWS - 1)) state_d = BN_SUB;
      BN_SUB:    state_d = BN_OUT;
      BN_OUT:    state_d = BN_RETURN;
      BN_RETURN: state_d = BN_IDLE;
      default:   state_d = BN_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    done = (state_q == BN_RETURN);
  end

  assign llr_out  = llr_out_q;
  assign sign_out = sign_out_q;
  assign hard_bit = hard_bit_q;

  // ----------------------------------------------------------------- datapath
  always_comb begin
    deg_d      = deg_q;
    mag_d      = mag_q;
    sgn_d      = sgn_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    llr_out_d  = llr_out_q;
    sign_out_d = sign_out_q;
    hard_bit_d = hard_bit_q;
    for (int j = 0; j < MAX_ROWS; j++) ext_d[j] = ext_q[j];

    case (state_q)
      BN_IDLE: begin
        if (start) begin
          deg_d = deg_clamped;
          mag_d = llr_in;
          sgn_d = sign_in;
          acc_d = to_tc(ch_sign_in, ch_llr_in);
          idx_d = '0;
        end
      end
      BN_ACC: begin
        if (DEG_W'(idx_q) < deg_q)
          acc_d = acc_q + to_tc(sgn_q[idx_q], mag_q[idx_q*WIDTH_LLR +: WIDTH_LLR]);
        idx_d = idx_q + 1'b1;
      end
      BN_SUB: begin
        // Extrinsic value: remove each edge's own contribution from the total.
        for (int j = 0; j < MAX_ROWS; j++) begin
          if (j < int'(deg_q))
            ext_d[j] = acc_q - to_tc(sgn_q[j], mag_q[j*WIDTH_LLR +: WIDTH_LLR]);
          else
            ext_d[j] = '0;
        end
      end
      BN_OUT: begin
        for (int j = 0; j < MAX_ROWS; j++) begin
          llr_out_d[j*WIDTH_LLR +: WIDTH_LLR] = sat_mag[j];
          sign_out_d[j]                       = sat_sgn[j];
        end
        hard_bit_d = acc_q[SUM_W-1];
      end
      default: ;
    endcase
  end

  // Saturating conversion back to sign-magnitude, one per edge.
  generate
    for (genvar g = 0; g < MAX_ROWS; g++) begin : g_sat
      llr_tc2sm #(
        .IN_W  (SUM_W),
        .OUT_W (WIDTH_LLR)
      ) u_tc2sm (
        .val  (ext_q[g]),
        .mag  (sat_mag[g]),
        .sign (sat_sgn[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire
